fpu_lane_sequencer: RTL and testbench

FPU_LANE_SEQUENCER -- requirements
Module: fpu_lane_sequencer

---
 rtl/fpu_lane_sequencer.sv | 163 ++++++++++++++++
 tb/tb_fpu_lane_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_lane_sequencer.sv
// Splits a wide SIMD FPU request into CORE_LANES-wide beats for a narrow FPU core.
// Fully masked beats are skipped; beat results may return out of order and are reassembled.
module fpu_lane_sequencer #(
  parameter int  LANES      = 16,
  parameter int  CORE_LANES = 4,
  parameter int  LANE_W     = 32,
  parameter int  TAG_WIDTH  = 1,
  localparam int BEATS      = LANES / CORE_LANES,
  localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [LANES*LANE_W-1:0]      req_bits_operands_0,
  input  logic [LANES*LANE_W-1:0]      req_bits_operands_1,
  input  logic [LANES*LANE_W-1:0]      req_bits_operands_2,
  input  logic [15:0]                  req_bits_ctrl,
  input  logic [TAG_WIDTH-1:0]         req_bits_tag,
  input  logic [LANES-1:0]             req_bits_simdMask,
  input  logic                         flush,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [LANES*LANE_W-1:0]      resp_bits_result,
  output logic [4:0]                   resp_bits_status,
  output logic [TAG_WIDTH-1:0]         resp_bits_tag,
  output logic                         busy,
  output logic                         core_req_valid,
  input  logic                         core_req_ready,
  output logic [CORE_LANES*LANE_W-1:0] core_req_operands_0,
  output logic [CORE_LANES*LANE_W-1:0] core_req_operands_1,
  output logic [CORE_LANES*LANE_W-1:0] core_req_operands_2,
  output logic [15:0]                  core_req_ctrl,
  output logic [CORE_LANES-1:0]        core_req_simdMask,
  output logic [BW-1:0]                core_req_tag,
  input  logic                         core_resp_valid,
  output logic                         core_resp_ready,
  input  logic [CORE_LANES*LANE_W-1:0] core_resp_result,
  input  logic [4:0]                   core_resp_status,
  input  logic [BW-1:0]                core_resp_tag,
  output logic                         core_flush
);

  localparam int CW = CORE_LANES * LANE_W;
  localparam int DW = LANES * LANE_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  if (LANES % CORE_LANES != 0) begin : g_bad_cfg
    $error("LANES must be a multiple of CORE_LANES");
  end

  logic [1:0]           state_q;
  logic [DW-1:0]        op0_q, op1_q, op2_q;
  logic [15:0]          ctrl_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [LANES-1:0]     mask_q;
  logic [DW-1:0]        result_q;
  logic [4:0]           status_q;
  logic [BW:0]          count_q, count_nxt;
  logic [BEATS-1:0]     pending_q, pending_clr, req_beat_nz;
  logic [BW-1:0]        cur_beat;
  logic                 accept, issue_fire, resp_take, flush_act;

  // pending_q holds one bit per beat still to issue; the lowest set bit is the issue pointer,
  // so empty beats are never visited and cost no cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cur_beat    = '0;
    req_beat_nz = '0;
    for (int b = BEATS - 1; b >= 0; b--) begin
      if (pending_q[b]) cur_beat = BW'(b);
    end
    for (int b = 0; b < BEATS; b++) begin
      req_beat_nz[b] = |req_bits_simdMask[b*CORE_LANES +: CORE_LANES];
    end
  end

  assign pending_clr = pending_q & ~(BEATS'(1) << cur_beat);
  assign flush_act   = flush && (state_q != IDLE);
  assign accept      = req_valid && (state_q == IDLE);
  assign issue_fire  = core_req_valid && core_req_ready;
  assign resp_take   = core_resp_valid && ((state_q == ISSUE) || (state_q == WAIT));
  assign count_nxt   = count_q + (BW+1)'(issue_fire) - (BW+1)'(resp_take);

  assign req_ready        = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign resp_valid       = (state_q == RESP);
  assign resp_bits_result = result_q;
  assign resp_bits_status = status_q;
  assign resp_bits_tag    = tag_q;

  assign core_req_valid      = (state_q == ISSUE);
  assign core_req_operands_0 = op0_q[int'(cur_beat)*CW +: CW];
  assign core_req_operands_1 = op1_q[int'(cur_beat)*CW +: CW];
  assign core_req_operands_2 = op2_q[int'(cur_beat)*CW +: CW];
  assign core_req_ctrl       = ctrl_q;
  assign core_req_simdMask   = mask_q[int'(cur_beat)*CORE_LANES +: CORE_LANES];
  assign core_req_tag        = cur_beat;
  assign core_resp_ready     = 1'b1;
  assign core_flush          = flush_act;

  // NOTE: request payload registers carry no reset; nothing reads them before an accept loads them.
  always_ff @(posedge clock) begin
    if (accept) begin
      op0_q  <= req_bits_operands_0;
      op1_q  <= req_bits_operands_1;
      op2_q  <= req_bits_operands_2;
      ctrl_q <= req_bits_ctrl;
      tag_q  <= req_bits_tag;
      mask_q <= req_bits_simdMask;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      status_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else if (flush_act) begin
      state_q   <= IDLE;
      status_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      if (resp_take) begin
        result_q[int'(core_resp_tag)*CW +: CW] <= core_resp_result;
        status_q <= status_q | core_resp_status;
      end
      count_q <= count_nxt;
      if (issue_fire) pending_q <= pending_clr;

      case (state_q)
        IDLE: begin
          if (req_valid) begin
            result_q  <= '0;
            status_q  <= '0;
            count_q   <= '0;
            pending_q <= req_beat_nz;
            state_q   <= (|req_beat_nz) ? ISSUE : RESP;
          end
        end
        ISSUE: begin
          if (issue_fire && (pending_clr == '0)) state_q <= (count_nxt == '0) ? RESP : WAIT;
        end
        WAIT: begin
          if (count_nxt == '0) state_q <= RESP;
        end
        RESP: begin
          if (resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_lane_sequencer.sv
// Directed bench for fpu_lane_sequencer: a behavioural FPU core with per-beat latency
// and status returns results; every expectation is computed from the bench's own stimulus.
module tb_fpu_lane_sequencer;

  localparam int LANES = 16;
  localparam int CL    = 4;
  localparam int LW    = 32;
  localparam int BEATS = LANES / CL;
  localparam int DW    = LANES * LW;
  localparam int CW    = CL * LW;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic           req_valid, req_ready;
  logic [DW-1:0]  req_bits_operands_0, req_bits_operands_1, req_bits_operands_2;
  logic [15:0]    req_bits_ctrl;
  logic [0:0]     req_bits_tag;
  logic [LANES-1:0] req_bits_simdMask;
  logic           flush;
  logic           resp_valid, resp_ready;
  logic [DW-1:0]  resp_bits_result;
  logic [4:0]     resp_bits_status;
  logic [0:0]     resp_bits_tag;
  logic           busy;
  logic           core_req_valid, core_req_ready;
  logic [CW-1:0]  core_req_operands_0, core_req_operands_1, core_req_operands_2;
  logic [15:0]    core_req_ctrl;
  logic [CL-1:0]  core_req_simdMask;
  logic [1:0]     core_req_tag;
  logic           core_resp_valid, core_resp_ready;
  logic [CW-1:0]  core_resp_result;
  logic [4:0]     core_resp_status;
  logic [1:0]     core_resp_tag;
  logic           core_flush;

  fpu_lane_sequencer #(.LANES(LANES), .CORE_LANES(CL), .LANE_W(LW), .TAG_WIDTH(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_bits_operands_0(req_bits_operands_0), .req_bits_operands_1(req_bits_operands_1),
    .req_bits_operands_2(req_bits_operands_2), .req_bits_ctrl(req_bits_ctrl),
    .req_bits_tag(req_bits_tag), .req_bits_simdMask(req_bits_simdMask), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_bits_result(resp_bits_result),
    .resp_bits_status(resp_bits_status), .resp_bits_tag(resp_bits_tag), .busy(busy),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_operands_0(core_req_operands_0), .core_req_operands_1(core_req_operands_1),
    .core_req_operands_2(core_req_operands_2), .core_req_ctrl(core_req_ctrl),
    .core_req_simdMask(core_req_simdMask), .core_req_tag(core_req_tag),
    .core_resp_valid(core_resp_valid), .core_resp_ready(core_resp_ready),
    .core_resp_result(core_resp_result), .core_resp_status(core_resp_status),
    .core_resp_tag(core_resp_tag), .core_flush(core_flush)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Behavioural core function: each lane returns (a + b) ^ c.
  function automatic logic [CW-1:0] core_fn(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                            input logic [CW-1:0] c);
    logic [CW-1:0] r;
    r = '0;
    for (int l = 0; l < CL; l++) r[l*LW +: LW] = (a[l*LW +: LW] + b[l*LW +: LW]) ^ c[l*LW +: LW];
    return r;
  endfunction

  // Stimulus and expectations
  logic [DW-1:0]    op0_v, op1_v, op2_v, exp_res;
  logic [LANES-1:0] mask_v;
  logic [15:0]      ctrl_v = 16'hA5C3;
  logic [0:0]       tag_v = 1'b1;
  logic [4:0]       exp_stat;
  int               exp_tags[$];
  int               acc_cyc, resp_cyc;

  // Core model state
  int            cyc = 0;
  int            delay_of[BEATS];
  logic [4:0]    stat_of[BEATS];
  bit            armed[BEATS];
  int            due[BEATS];
  logic [CW-1:0] res_of[BEATS];
  int            issue_tags[$], ret_tags[$];
  int            first_issue_cyc, last_ret_cyc;
  bit            ready_toggle = 1'b0;

  initial begin
    bit            stall_pending;
    int            stall_tag, t, best;
    logic [CW-1:0] stall_op;
    stall_pending = 1'b0;
    core_resp_valid = 1'b0; core_resp_result = '0; core_resp_status = '0; core_resp_tag = '0;
    core_req_ready = 1'b1;
    for (int i = 0; i < BEATS; i++) armed[i] = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        for (int i = 0; i < BEATS; i++) armed[i] = 1'b0;
        stall_pending = 1'b0;
      end else if (core_flush) begin
        stall_pending = 1'b0;
      end else if (core_req_valid) begin
        t = int'(core_req_tag);
        if (stall_pending) begin
          check("req_hold_tag", core_req_tag, stall_tag);
          check("req_hold_op0", core_req_operands_0, stall_op);
        end
        if (core_req_ready) begin
          stall_pending = 1'b0;
          if (issue_tags.size() == 0) first_issue_cyc = cyc;
          issue_tags.push_back(t);
          check($sformatf("req_op0_b%0d", t), core_req_operands_0, op0_v[t*CW +: CW]);
          check($sformatf("req_op2_b%0d", t), core_req_operands_2, op2_v[t*CW +: CW]);
          check($sformatf("req_mask_b%0d", t), core_req_simdMask, mask_v[t*CL +: CL]);
          res_of[t] = core_fn(core_req_operands_0, core_req_operands_1, core_req_operands_2);
          armed[t]  = 1'b1;
          due[t]    = cyc + delay_of[t];
        end else begin
          stall_pending = 1'b1;
          stall_tag     = t;
          stall_op      = core_req_operands_0;
        end
      end else if (stall_pending) begin
        check("req_withdrawn", core_req_valid, 1);
        stall_pending = 1'b0;
      end
      @(posedge clock);
      #1;
      cyc++;
      if (ready_toggle) core_req_ready = ~core_req_ready;
      core_resp_valid = 1'b0;
      best = -1;
      for (int i = 0; i < BEATS; i++)
        if (armed[i] && due[i] <= cyc && (best < 0 || due[i] < due[best])) best = i;
      if (best >= 0) begin
        core_resp_valid  = 1'b1;
        core_resp_tag    = 2'(best);
        core_resp_result = res_of[best];
        core_resp_status = stat_of[best];
        armed[best]      = 1'b0;
        ret_tags.push_back(best);
        last_ret_cyc     = cyc;
      end
    end
  end

  task automatic set_core(input int d0, input int d1, input int d2, input int d3,
                          input logic [4:0] s0, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [4:0] s3);
    delay_of[0] = d0; delay_of[1] = d1; delay_of[2] = d2; delay_of[3] = d3;
    stat_of[0] = s0; stat_of[1] = s1; stat_of[2] = s2; stat_of[3] = s3;
  endtask

  task automatic start_req(input logic [LANES-1:0] m);
    for (int l = 0; l < LANES; l++) begin
      op0_v[l*LW +: LW] = $urandom();
      op1_v[l*LW +: LW] = $urandom();
      op2_v[l*LW +: LW] = $urandom();
    end
    mask_v = m;
    exp_res = '0;
    exp_stat = '0;
    exp_tags.delete();
    for (int b = 0; b < BEATS; b++) begin
      if (|m[b*CL +: CL]) begin
        exp_res[b*CW +: CW] = core_fn(op0_v[b*CW +: CW], op1_v[b*CW +: CW], op2_v[b*CW +: CW]);
        exp_stat = exp_stat | stat_of[b];
        exp_tags.push_back(b);
      end
    end
    issue_tags.delete();
    ret_tags.delete();
    ctrl_v = ctrl_v + 16'h0101;
    @(posedge clock);
    #1;
    req_bits_operands_0 = op0_v;
    req_bits_operands_1 = op1_v;
    req_bits_operands_2 = op2_v;
    req_bits_ctrl       = ctrl_v;
    req_bits_tag        = tag_v;
    req_bits_simdMask   = m;
    req_valid           = 1'b1;
    @(negedge clock);
    check("accept_ready", req_ready, 1);
    acc_cyc = cyc;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    check("busy_after_accept", busy, 1);
    check("first_core_req", core_req_valid, (m != '0));
    if (m != '0) check("core_ctrl", core_req_ctrl, ctrl_v);
  endtask

  task automatic finish_req(input int hold, input bit chk_latency);
    int n;
    n = 0;
    while (!resp_valid && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("resp_seen", resp_valid, 1);
    if (!resp_valid) return;
    resp_cyc = cyc;
    check("resp_result", resp_bits_result, exp_res);
    check("resp_status", resp_bits_status, exp_stat);
    check("resp_tag", resp_bits_tag, tag_v);
    check("n_issued", issue_tags.size(), exp_tags.size());
    for (int i = 0; i < exp_tags.size() && i < issue_tags.size(); i++)
      check($sformatf("issue_tag%0d", i), issue_tags[i], exp_tags[i]);
    check("n_returned", ret_tags.size(), exp_tags.size());
    if (chk_latency) begin
      if (exp_tags.size() == 0) begin
        check("resp_latency_empty", resp_cyc, acc_cyc + 1);
      end else begin
        check("first_issue_latency", first_issue_cyc, acc_cyc + 1);
        check("resp_latency", resp_cyc, last_ret_cyc + 1);
      end
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      check("hold_valid", resp_valid, 1);
      check("hold_req_ready", req_ready, 0);
      check("hold_result", resp_bits_result, exp_res);
      check("hold_status", resp_bits_status, exp_stat);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    @(negedge clock);
    check("resp_done_valid", resp_valid, 0);
    check("resp_done_ready", req_ready, 1);
    tag_v = ~tag_v;
  endtask

  initial begin
    int            n;
    bit            any_resp;
    logic [DW-1:0] r;
    req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    req_bits_operands_0 = '0; req_bits_operands_1 = '0; req_bits_operands_2 = '0;
    req_bits_ctrl = '0; req_bits_tag = '0; req_bits_simdMask = '0;
    op0_v = '0; op1_v = '0; op2_v = '0; mask_v = '0;
    set_core(2, 2, 2, 2, 5'h00, 5'h00, 5'h00, 5'h00);

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_core_req_valid", core_req_valid, 0);
    check("rst_core_flush", core_flush, 0);
    check("rst_busy", busy, 0);
    check("rst_result", resp_bits_result, '0);
    check("rst_status", resp_bits_status, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Full mask, 2-cycle core latency
    set_core(2, 2, 2, 2, 5'h00, 5'h00, 5'h00, 5'h00);
    start_req(16'hFFFF);
    finish_req(0, 1'b1);

    // Alternate beats masked off
    start_req(16'h0F0F);
    finish_req(0, 1'b1);
    r = resp_bits_result;
    check("skip_lanes_4_7", r[1*CW +: CW], '0);
    check("skip_lanes_12_15", r[3*CW +: CW], '0);

    // Empty mask answers immediately
    set_core(2, 2, 2, 2, 5'h1F, 5'h1F, 5'h1F, 5'h1F);
    start_req(16'h0000);
    finish_req(0, 1'b1);

    // Sparse single lanes in two beats, with status
    set_core(3, 2, 2, 1, 5'h04, 5'h00, 5'h00, 5'h08);
    start_req(16'h8001);
    finish_req(0, 1'b1);

    // Out-of-order returns 3,1,0,2 with per-beat status
    set_core(7, 5, 6, 2, 5'h00, 5'h01, 5'h00, 5'h10);
    start_req(16'hFFFF);
    finish_req(0, 1'b1);
    check("ooo_ret0", ret_tags.size() > 0 ? ret_tags[0] : -1, 3);
    check("ooo_ret1", ret_tags.size() > 1 ? ret_tags[1] : -1, 1);
    check("ooo_ret2", ret_tags.size() > 2 ? ret_tags[2] : -1, 0);
    check("ooo_ret3", ret_tags.size() > 3 ? ret_tags[3] : -1, 2);
    check("ooo_status", resp_bits_status, 5'h11);

    // Flush in WAIT with two beats outstanding; stale returns arrive later in IDLE
    set_core(2, 2, 30, 30, 5'h02, 5'h00, 5'h04, 5'h08);
    start_req(16'hFFFF);
    n = 0;
    while (!(issue_tags.size() == 4 && ret_tags.size() == 2) && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("flush_setup", (issue_tags.size() == 4 && ret_tags.size() == 2), 1);
    @(posedge clock);
    #1;
    flush = 1'b1;
    @(negedge clock);
    check("flush_pulse", core_flush, 1);
    check("flush_busy", busy, 1);
    @(negedge clock);
    check("flush_pulse_once", core_flush, 0);
    check("flush_idle_busy", busy, 0);
    check("flush_idle_ready", req_ready, 1);
    @(posedge clock);
    #1;
    flush = 1'b0;
    any_resp = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (resp_valid) any_resp = 1'b1;
    end
    check("flush_no_resp", any_resp, 0);
    check("stale_returned", ret_tags.size(), 4);
    check("stale_status", resp_bits_status, 0);
    r = resp_bits_result;
    check("stale_slice2", r[2*CW +: CW], '0);
    check("stale_slice3", r[3*CW +: CW], '0);

    set_core(2, 2, 2, 2, 5'h00, 5'h00, 5'h00, 5'h00);
    start_req(16'hFFFF);
    finish_req(0, 1'b1);

    // Backpressure on both sides: toggling core_req_ready, resp_ready low for 5 cycles
    set_core(3, 1, 2, 2, 5'h00, 5'h02, 5'h00, 5'h00);
    ready_toggle = 1'b1;
    start_req(16'hF0FF);
    finish_req(5, 1'b0);
    ready_toggle = 1'b0;
    core_req_ready = 1'b1;

    // Reset mid-operation discards all work
    set_core(4, 4, 4, 4, 5'h00, 5'h00, 5'h00, 5'h00);
    start_req(16'hFFFF);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_req_ready", req_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_core_req_valid", core_req_valid, 0);
    check("midrst_result", resp_bits_result, '0);
    @(negedge clock);
    #2;
    reset_n = 1'b1;
    any_resp = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (resp_valid || busy) any_resp = 1'b1;
    end
    check("midrst_no_resp", any_resp, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
